// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: sequencer for an iterative carry-save CORDIC datapath (rotation mode)
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   start handshake, z_in is the initial angle
//   out_valid/out_ready result handshake, z_res is the final angle residual
//   dp_load, dp_en      datapath load pulse and per-iteration enable pulse
//   shift               iteration index (shift amount and atan ROM address)
//   atan_val            arctan(2^-shift) from the external ROM
//   add_sub_x/y         per-path subtract controls, valid only with dp_en
//   busy                high whenever an operation is in flight
module cordic_iter_ctrl #(
    parameter int W      = 16,
    parameter int N_ITER = 12,
    parameter int DP_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              z_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      dp_load,
    output logic                      dp_en,
    output logic [$clog2(N_ITER)-1:0] shift,
    input  logic [W-1:0]              atan_val,
    output logic                      add_sub_x,
    output logic                      add_sub_y,
    output logic                      busy,
    output logic [W-1:0]              z_res
);
    localparam int IW = $clog2(N_ITER);
    localparam int SW = DP_LAT > 1 ? $clog2(DP_LAT) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ITER = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [W-1:0]  z;
    logic [IW-1:0] iter;
    logic [SW-1:0] sub;
    logic          dir;

    // z >= 0 rotates clockwise-to-zero: subtract the atan step
    assign dir       = ~z[W-1];
    assign in_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign dp_load   = state == LOAD;
    assign dp_en     = state == ITER && sub == '0;
    assign out_valid = state == DONE;
    assign shift     = state == ITER ? iter : '0;
    assign add_sub_x = dp_en & dir;
    assign add_sub_y = dp_en & ~dir;
    assign z_res     = z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            z     <= '0;
            iter  <= '0;
            sub   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z     <= z_in;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    iter  <= '0;
                    sub   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    if (sub == '0)
                        z <= dir ? z - atan_val : z + atan_val;
                    if (sub == SW'(DP_LAT - 1)) begin
                        sub <= '0;
                        // counter wraps to 0 on the last iteration so it fits in $clog2(N_ITER) bits
                        if (iter == IW'(N_ITER - 1)) begin
                            iter  <= '0;
                            state <= DONE;
                        end else begin
                            iter <= iter + 1'b1;
                        end
                    end else begin
                        sub <= sub + 1'b1;
                    end
                end
                default: begin
                    if (out_ready)
                        state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl: randomized self-checking bench with a cycle-relative behavioural model
module tb_cordic_iter_ctrl;
    localparam int W      = 16;
    localparam int N_ITER = 12;
    localparam int DP_LAT = 2;
    localparam int NL     = N_ITER * DP_LAT;

    logic          clk = 0;
    logic          reset = 1;
    logic          in_valid = 0;
    logic          in_ready;
    logic [W-1:0]  z_in = '0;
    logic          out_valid;
    logic          out_ready = 0;
    logic          dp_load;
    logic          dp_en;
    logic [3:0]    shift;
    logic [W-1:0]  atan_val;
    logic          add_sub_x;
    logic          add_sub_y;
    logic          busy;
    logic [W-1:0]  z_res;

    logic [W-1:0]  rom [16];
    int            total = 0;
    int            bad = 0;
    bit            en = 0;

    cordic_iter_ctrl #(.W(W), .N_ITER(N_ITER), .DP_LAT(DP_LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready), .dp_load(dp_load), .dp_en(dp_en),
        .shift(shift), .atan_val(atan_val), .add_sub_x(add_sub_x), .add_sub_y(add_sub_y),
        .busy(busy), .z_res(z_res)
    );

    always #5 clk = ~clk;
    assign atan_val = rom[shift];

    // Model: an operation is described by cycles elapsed since its accept cycle (m_t)
    bit           m_busy = 0;
    int           m_t = 0;
    logic [W-1:0] m_z = '0;
    logic         e_iter, e_dp_en, e_load, e_out_valid;
    int           e_i, e_shift;
    assign e_iter      = m_busy && m_t >= 2 && m_t < 2 + NL;
    assign e_i         = (m_t - 2) / DP_LAT;
    assign e_dp_en     = e_iter && ((m_t - 2) % DP_LAT == 0);
    assign e_shift     = e_iter ? e_i : 0;
    assign e_load      = m_busy && m_t == 1;
    assign e_out_valid = m_busy && m_t >= 2 + NL;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_t = 0; m_z = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1; m_t = 1; m_z = z_in;
            end
        end else begin
            if (e_dp_en) m_z = m_z[W-1] ? m_z + rom[e_i] : m_z - rom[e_i];
            if (e_out_valid) begin
                if (out_ready) m_busy = 0;
            end else begin
                m_t++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("dp_load", 32'(dp_load), 32'(e_load));
            chk("dp_en", 32'(dp_en), 32'(e_dp_en));
            chk("shift", 32'(shift), e_shift);
            chk("add_sub_x", 32'(add_sub_x), 32'(e_dp_en && !m_z[W-1]));
            chk("add_sub_y", 32'(add_sub_y), 32'(e_dp_en && m_z[W-1]));
            chk("out_valid", 32'(out_valid), 32'(e_out_valid));
            if (e_out_valid) chk("z_res", 32'(z_res), 32'(m_z));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic lat_op(input logic [W-1:0] z, input bit dir);
        int n_en = 0;
        int first = -1;
        int ld = -1;
        chk("accept_ready", 32'(in_ready), 1);
        in_valid = 1; z_in = z;
        cyc();
        in_valid = 0; z_in = 16'($urandom);
        for (int c = 1; c <= 40 && first < 0; c++) begin
            if (dp_load) ld = (ld < 0) ? c : 999;
            if (dp_en) begin
                chk("en_cycle", c, 2 + DP_LAT * n_en);
                n_en++;
            end
            if (out_valid) first = c;
            if (dir && c == 2) begin
                chk("dir0_en", 32'(dp_en), 1);
                chk("dir0_shift", 32'(shift), 0);
                chk("dir0_asx", 32'(add_sub_x), 1);
                chk("dir0_asy", 32'(add_sub_y), 0);
            end
            if (dir && c == 3) chk("model_z1", 32'(m_z), 32'h0000E6DE);
            if (dir && c == 4) begin
                chk("dir1_shift", 32'(shift), 1);
                chk("dir1_asx", 32'(add_sub_x), 0);
                chk("dir1_asy", 32'(add_sub_y), 1);
            end
            if (dir && c == 5) chk("model_z2", 32'(m_z), 32'h0000F5B4);
            if (first < 0) cyc();
        end
        chk("load_cycle", ld, 1);
        chk("en_count", n_en, 12);
        chk("ov_cycle", first, 26);
    endtask

    initial begin
        logic [W-1:0] zr;
        bit found;
        int prev;
        rom[0] = 16'h1922; rom[1] = 16'h0ED6; rom[2] = 16'h07D7; rom[3] = 16'h03FB;
        rom[4] = 16'h01FF; rom[5] = 16'h0100; rom[6] = 16'h0080; rom[7] = 16'h0040;
        rom[8] = 16'h0020; rom[9] = 16'h0010; rom[10] = 16'h0008; rom[11] = 16'h0004;
        for (int k = 12; k < 16; k++) rom[k] = '0;
        cyc(); cyc();
        reset = 0; en = 1;
        cyc();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_dp_load", 32'(dp_load), 0);
        chk("rst_shift", 32'(shift), 0);
        chk("rst_z_res", 32'(z_res), 0);
        cyc(); cyc();
        chk("idle_no_load", 32'(dp_load), 0);

        lat_op(16'h0000, 1);
        in_valid = 1; z_in = 16'h7777;
        zr = z_res;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_z_res", 32'(z_res), 32'(zr));
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1;
        cyc();
        chk("hs_idle", 32'(in_ready), 1);
        cyc();
        chk("hs_accepted", 32'(dp_load), 1);
        in_valid = 0;

        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (dp_en && shift == 4'd5) found = 1;
            else cyc();
        end
        chk("found_iter5", 32'(found), 1);
        reset = 1;
        cyc();
        reset = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_z_res", 32'(z_res), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        lat_op(16'($urandom), 0);
        cyc();

        in_valid = 1;
        prev = -1;
        for (int c = 0; c < 150; c++) begin
            if (in_ready) begin
                if (prev >= 0) chk("b2b_gap", c - prev, 27);
                prev = c;
            end
            z_in = 16'($urandom);
            cyc();
        end
        in_valid = 0;

        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(1));
            out_ready = $urandom_range(3) != 0;
            z_in      = 16'($urandom);
            reset     = $urandom_range(199) == 0;
            cyc();
        end
        reset = 0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
